eth_tx_fcs_inserter: RTL and testbench



---
 rtl/eth_tx_fcs_inserter.sv | 231 +++++++++++++++++++++++
 tb/tb_eth_tx_fcs_inserter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_fcs_inserter.sv
// Ethernet TX FCS inserter: runs CRC-32 over a 64-bit frame stream (word step for
// full words, byte step for the tail word) and appends the 4 FCS bytes to the frame.
module eth_tx_fcs_inserter #(
    parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
    parameter bit          APPEND_FCS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] s_data,
    input  logic [7:0]  s_keep,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [63:0] m_data,
    output logic [7:0]  m_keep,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic [31:0] fcs,
    output logic        fcs_valid
);
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {PASS = 2'd0, TAIL = 2'd1, FCSW = 2'd2, SPILL = 2'd3} state_t;

    // MSB-first CRC step; byte bit 0 enters the register first
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [63:0] w);
        logic [31:0] r;
        r = c;
        for (int j = 0; j < 8; j++) r = crc_byte(r, w[8*j +: 8]);
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    function automatic logic [63:0] byte_mask(input logic [7:0] k);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    state_t      state_r, state_next_s;
    logic [31:0] crc_r;
    logic [63:0] hold_r;
    logic [3:0]  k_r;
    logic [7:0]  keep_r;
    logic [2:0]  idx_r;
    logic [31:0] spill_r;

    logic        out_free_s, s_ready_s, accept_s, load_fin_s, byte_step_s, tail_done_s;
    logic [3:0]  in_k_s, fin_k_s;
    logic [31:0] crc_word_s, crc_after_s, fin_crc_s, fcs_s;
    logic [63:0] fin_data_s, fin_word_s;
    logic [7:0]  fin_keep_s, fin_keep_out_s, spill_keep_s;
    logic        fin_last_s;
    logic [95:0] combined_s;

    assign out_free_s  = !m_valid || m_ready;
    assign accept_s    = s_valid && s_ready_s;
    assign in_k_s      = popcount8(s_keep);
    assign crc_word_s  = crc_word(crc_r, s_data);
    assign byte_step_s = {1'b0, idx_r} < k_r;
    assign tail_done_s = ({1'b0, idx_r} + 4'd1) >= k_r;
    assign crc_after_s = byte_step_s ? crc_byte(crc_r, hold_r[{idx_r, 3'b000} +: 8]) : crc_r;
    assign s_ready     = s_ready_s;

    // FCS lands right after the last payload byte; whatever passes lane 7 spills over
    assign fcs_s          = ~bitrev32(fin_crc_s);
    assign combined_s     = {32'd0, fin_data_s & byte_mask(fin_keep_s)}
                          | ({64'd0, fcs_s} << {fin_k_s, 3'b000});
    assign fin_word_s     = APPEND_FCS ? combined_s[63:0] : fin_data_s;
    assign fin_keep_out_s = !APPEND_FCS ? fin_keep_s
                          : (fin_k_s >= 4'd4) ? 8'hFF : (8'hFF >> (4'd4 - fin_k_s));
    assign fin_last_s     = APPEND_FCS ? (fin_k_s <= 4'd4) : 1'b1;
    assign spill_keep_s   = 8'hFF >> (4'd12 - k_r);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= PASS;
        else     state_r <= state_next_s;
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            PASS: begin
                if (accept_s && s_last) begin
                    if (in_k_s == 4'd0 || in_k_s == 4'd8) state_next_s = FCSW;
                    else                                  state_next_s = TAIL;
                end else begin
                    state_next_s = PASS;
                end
            end
            TAIL: begin
                if (load_fin_s) state_next_s = FCSW;
                else            state_next_s = TAIL;
            end
            FCSW: begin
                if (m_valid && m_ready) state_next_s = (APPEND_FCS && k_r > 4'd4) ? SPILL : PASS;
                else                    state_next_s = FCSW;
            end
            SPILL: begin
                if (m_valid && m_ready) state_next_s = PASS;
                else                    state_next_s = SPILL;
            end
            default: state_next_s = PASS;
        endcase
    end

    // Handshake and final-word source selection
    always_comb begin
        s_ready_s  = 1'b0;
        load_fin_s = 1'b0;
        fin_data_s = hold_r;
        fin_k_s    = k_r;
        fin_keep_s = keep_r;
        fin_crc_s  = crc_after_s;
        case (state_r)
            PASS: begin
                s_ready_s  = out_free_s && !rst;
                fin_data_s = s_data;
                fin_k_s    = in_k_s;
                fin_keep_s = s_keep;
                fin_crc_s  = (in_k_s == 4'd8) ? crc_word_s : crc_r;
                if (accept_s && s_last && (in_k_s == 4'd0 || in_k_s == 4'd8)) load_fin_s = 1'b1;
                else                                                           load_fin_s = 1'b0;
            end
            TAIL: begin
                if (tail_done_s && out_free_s) load_fin_s = 1'b1;
                else                           load_fin_s = 1'b0;
            end
            default: begin
                s_ready_s  = 1'b0;
                load_fin_s = 1'b0;
            end
        endcase
    end

    // Datapath: CRC register, tail holding word and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_r     <= CRC_INIT;
            hold_r    <= 64'd0;
            k_r       <= 4'd0;
            keep_r    <= 8'd0;
            idx_r     <= 3'd0;
            spill_r   <= 32'd0;
            m_data    <= 64'd0;
            m_keep    <= 8'd0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            fcs       <= 32'd0;
            fcs_valid <= 1'b0;
        end else begin
            fcs_valid <= 1'b0;
            if (m_valid && m_ready) m_valid <= 1'b0;
            case (state_r)
                PASS: begin
                    if (accept_s && !s_last) begin
                        crc_r   <= crc_word_s;
                        m_data  <= s_data;
                        m_keep  <= s_keep;
                        m_last  <= 1'b0;
                        m_valid <= 1'b1;
                    end else if (accept_s && !load_fin_s) begin
                        hold_r <= s_data;
                        k_r    <= in_k_s;
                        keep_r <= s_keep;
                        idx_r  <= 3'd0;
                    end
                end
                TAIL: begin
                    if (byte_step_s) begin
                        crc_r <= crc_after_s;
                        idx_r <= idx_r + 3'd1;
                    end
                end
                FCSW: begin
                    if (m_valid && m_ready) begin
                        if (APPEND_FCS && k_r > 4'd4) begin
                            m_data  <= {32'd0, spill_r};
                            m_keep  <= spill_keep_s;
                            m_last  <= 1'b1;
                            m_valid <= 1'b1;
                        end else begin
                            crc_r <= CRC_INIT;
                        end
                    end
                end
                SPILL: begin
                    if (m_valid && m_ready) crc_r <= CRC_INIT;
                end
                default: crc_r <= CRC_INIT;
            endcase
            if (load_fin_s) begin
                crc_r     <= fin_crc_s;
                k_r       <= fin_k_s;
                keep_r    <= fin_keep_s;
                spill_r   <= combined_s[95:64];
                m_data    <= fin_word_s;
                m_keep    <= fin_keep_out_s;
                m_last    <= fin_last_s;
                m_valid   <= 1'b1;
                fcs       <= fcs_s;
                fcs_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_eth_tx_fcs_inserter.sv
// Bench for eth_tx_fcs_inserter: random frames against a byte-stream model using the
// reflected CRC-32 (0xEDB88320), with random backpressure and input gaps.
module tb_eth_tx_fcs_inserter;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        s_valid, s_last, s_ready;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic        m_valid, m_last, m_ready;
    logic [31:0] fcs;
    logic        fcs_valid;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [63:0] d; logic [7:0] k; logic l; } word_t;
    word_t       in_q[$];
    word_t       exp_q[$];
    logic [31:0] exp_fcs[$];

    eth_tx_fcs_inserter dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .fcs(fcs), .fcs_valid(fcs_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_crc(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'd0, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [7:0] k);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    function automatic logic [7:0] keep_of(input int n);
        logic [7:0] one;
        one = 8'd1;
        return (n >= 8) ? 8'hFF : ((one << n) - 8'd1);
    endfunction

    // Build one frame: input words, expected output words (payload ++ FCS bytes) and FCS
    task automatic gen_random(input int nwords, input int k);
        logic [7:0] pl[$];
        logic [7:0] st[$];
        logic [31:0] c;
        word_t w;
        int total;
        total = 8 * (nwords - 1) + k;
        for (int i = 0; i < total; i++) pl.push_back(8'($urandom));
        for (int wi = 0; wi < nwords; wi++) begin
            for (int b = 0; b < 8; b++)
                w.d[8*b +: 8] = (8*wi + b < total) ? pl[8*wi + b] : 8'($urandom);
            w.k = (wi < nwords - 1) ? 8'hFF : keep_of(k);
            w.l = (wi == nwords - 1);
            in_q.push_back(w);
        end
        c = ref_crc(pl);
        exp_fcs.push_back(c);
        st = pl;
        for (int i = 0; i < 4; i++) st.push_back(c[8*i +: 8]);
        for (int o = 0; o < st.size(); o += 8) begin
            int cnt;
            cnt = (st.size() - o >= 8) ? 8 : st.size() - o;
            w.d = 64'd0;
            for (int b = 0; b < cnt; b++) w.d[8*b +: 8] = st[o + b];
            w.k = keep_of(cnt);
            w.l = (o + 8 >= st.size());
            exp_q.push_back(w);
        end
    endtask

    // Drive queued input words and check every output handshake and FCS pulse
    task automatic run_traffic(input string tag, input int rdy_pct, input int gap_pct);
        word_t cur, w;
        bit pending = 1'b0;
        bit stall_prev = 1'b0;
        logic [63:0] pd;
        logic [7:0] pk;
        logic pl;
        logic [63:0] mk;
        int cyc = 0;
        while ((in_q.size() > 0 || pending || exp_q.size() > 0 || exp_fcs.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            m_ready = ($urandom_range(99) < rdy_pct);
            if (!pending && in_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                cur = in_q.pop_front();
                pending = 1'b1;
            end
            s_valid = pending;
            s_data  = pending ? cur.d : 64'd0;
            s_keep  = pending ? cur.k : 8'd0;
            s_last  = pending ? cur.l : 1'b0;
            #1;
            if (stall_prev) begin
                checks++;
                if (m_data !== pd || m_keep !== pk || m_last !== pl || m_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s stall_hold: got data=%h keep=%h last=%b valid=%b, want data=%h keep=%h last=%b valid=1",
                             tag, m_data, m_keep, m_last, m_valid, pd, pk, pl);
                end
            end
            if (m_valid && !m_ready) begin
                checks++;
                if (s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s s_ready_stall: got %b want 0", tag, s_ready);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_word: got data=%h keep=%h last=%b, want none", tag, m_data, m_keep, m_last);
                end else begin
                    w = exp_q.pop_front();
                    mk = lane_mask(w.k);
                    if ((m_data & mk) !== (w.d & mk) || m_keep !== w.k || m_last !== w.l) begin
                        errors++;
                        $display("FAIL %s out_word: got data=%h keep=%h last=%b, want data=%h keep=%h last=%b",
                                 tag, m_data & mk, m_keep, m_last, w.d & mk, w.k, w.l);
                    end
                end
            end
            if (fcs_valid) begin
                checks++;
                if (exp_fcs.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_fcs: got fcs=%h, want no pulse", tag, fcs);
                end else if (fcs !== exp_fcs[0]) begin
                    errors++;
                    $display("FAIL %s fcs: got %h want %h", tag, fcs, exp_fcs[0]);
                    void'(exp_fcs.pop_front());
                end else begin
                    void'(exp_fcs.pop_front());
                end
            end
            stall_prev = m_valid && !m_ready;
            pd = m_data;
            pk = m_keep;
            pl = m_last;
            if (s_valid && s_ready) pending = 1'b0;
        end
        if (cyc >= 20000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d words and %0d fcs still expected", tag, exp_q.size(), exp_fcs.size());
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        in_q.delete();
        exp_q.delete();
        exp_fcs.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = 64'd0; s_keep = 8'd0; s_last = 1'b0; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_s_ready: got %b want 0", s_ready);
        end
        checks++;
        if ({m_valid, m_last, m_keep, m_data, fcs, fcs_valid} !== 107'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b last=%b keep=%h data=%h fcs=%h fcs_valid=%b, want all 0",
                     m_valid, m_last, m_keep, m_data, fcs, fcs_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_s_ready: got %b want 1", s_ready);
        end
    endtask

    task automatic push_known();
        in_q.push_back('{64'h3837_3635_3433_3231, 8'hFF, 1'b0});
        in_q.push_back('{{56'($urandom), 8'h39}, 8'h01, 1'b1});
        exp_q.push_back('{64'h3837_3635_3433_3231, 8'hFF, 1'b0});
        exp_q.push_back('{64'h0000_00CB_F439_2639, 8'h1F, 1'b1});
        exp_fcs.push_back(32'hCBF4_3926);
    endtask

    task automatic test_known_vector();
        push_known();
        run_traffic("known", 100, 0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) push_known();
        run_traffic("backpressure", 20, 0);
    endtask

    task automatic test_k_sweep();
        for (int k = 0; k <= 8; k++) gen_random($urandom_range(1, 4), k);
        gen_random(8, 8);
        gen_random(3, 0);
        gen_random(1, 0);
        gen_random(2, 6);
        run_traffic("k_sweep", 100, 0);
    endtask

    task automatic test_latency();
        for (int k = 0; k <= 8; k++) begin
            int n;
            int want;
            in_q.delete(); exp_q.delete(); exp_fcs.delete();
            gen_random(1, k);
            @(negedge clk);
            m_ready = 1'b1; s_valid = 1'b1; s_data = in_q[0].d; s_keep = in_q[0].k; s_last = 1'b1;
            #1;
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("FAIL latency_ready k=%0d: got %b want 1", k, s_ready);
            end
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            n = 1;
            #1;
            while (!m_valid && n < 20) begin
                @(negedge clk);
                n++;
                #1;
            end
            want = (k == 0 || k == 8) ? 1 : 1 + k;
            checks++;
            if (n != want) begin
                errors++;
                $display("FAIL latency k=%0d: got %0d cycles want %0d", k, n, want);
            end
            checks++;
            if (fcs_valid !== 1'b1 || fcs !== exp_fcs[0]) begin
                errors++;
                $display("FAIL latency_fcs k=%0d: got fcs=%h valid=%b want fcs=%h valid=1", k, fcs, fcs_valid, exp_fcs[0]);
            end
            repeat (3) @(negedge clk);
        end
        in_q.delete(); exp_q.delete(); exp_fcs.delete();
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) gen_random($urandom_range(1, 6), $urandom_range(0, 8));
        run_traffic("random", 70, 30);
    endtask

    task automatic test_reset_mid_tail();
        int seen;
        @(negedge clk);
        m_ready = 1'b1; s_valid = 1'b1; s_data = {$urandom, $urandom}; s_keep = 8'hFF; s_last = 1'b0;
        @(negedge clk);
        s_data = {$urandom, $urandom}; s_keep = 8'h7F; s_last = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_tail_s_ready: got %b want 0", s_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_tail_state: got m_valid=%b s_ready=%b want m_valid=0 s_ready=1", m_valid, s_ready);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (m_valid || fcs_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_tail_discard: got %0d cycles of output want 0", seen);
        end
        gen_random(3, 5);
        gen_random(1, 2);
        run_traffic("after_reset", 100, 0);
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_backpressure();
        test_k_sweep();
        test_latency();
        test_random();
        test_reset_mid_tail();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
